// File: rtl/mem_resp_stage.sv
// ---------------------------------------------------------------------------
// mem_resp_stage
//   MEM pipeline stage of an in-order core. Holds the instruction coming from
//   EX, waits for the data-SRAM read response of an issued load, aligns and
//   extends the loaded data, and hands the result to WB. A response that
//   arrives while WB is stalled is parked in a one-entry buffer. Responses
//   belonging to loads squashed by a flush are counted and discarded when
//   they eventually arrive.
//
// Parameters
//   CNT_W            width of the cancelled-response counter (saturates at
//                    2^CNT_W-1)
//
// Ports
//   clk, resetn      clock (rising edge), asynchronous active-low reset
//   ex_to_mem_valid  EX holds a valid instruction for MEM
//   mem_allowin      MEM accepts an EX instruction this cycle
//   ex_rf_we/waddr   destination register write enable / index
//   ex_pc            instruction PC
//   ex_result        ALU result, or the load address for loads
//   ex_ld_op         one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}; zero = no load
//   ex_req_sent      the load request was accepted by the data SRAM
//   data_sram_*      read response strobe and data
//   flush            exception/ertn flush from WB, squashes MEM
//   wb_allowin       WB accepts this cycle
//   mem_to_wb_valid  MEM presents a completed instruction to WB
//   mem_rf_*, mem_pc payload to WB
//   mem_rf_zip       forwarding bus {we & valid, fwd_ready, waddr, wdata}
//
// Build option
//   MEM_RESP_FWD_EN  when defined, a load is marked forwardable in the cycle
//                    its data is available; otherwise loads never forward.
// ---------------------------------------------------------------------------
module mem_resp_stage #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_mem_valid,
  output logic        mem_allowin,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [4:0]  ex_ld_op,
  input  logic        ex_req_sent,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic        mem_rf_we,
  output logic [4:0]  mem_rf_waddr,
  output logic [31:0] mem_rf_wdata,
  output logic [31:0] mem_pc,
  output logic [38:0] mem_rf_zip
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned LDOP_W = 5;

  // Bit positions inside the one-hot load opcode
  localparam int unsigned LD_W_BIT  = 0;
  localparam int unsigned LD_HU_BIT = 1;
  localparam int unsigned LD_H_BIT  = 2;
  localparam int unsigned LD_BU_BIT = 3;
  localparam int unsigned LD_B_BIT  = 4;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef struct packed {
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   result;
    logic [LDOP_W-1:0] ld_op;
    logic              req_sent;
  } mem_payload_t;

  mem_payload_t      pl_q;
  logic              mem_valid_q, mem_valid_d;
  logic              buf_valid_q, buf_valid_d;
  logic [XLEN-1:0]   buf_data_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_load;
  logic              pending;
  logic              resp_own;
  logic              mem_ready_go;
  logic              to_wb_fire;
  logic              buf_capture;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              fwd_ready;

  logic [XLEN-1:0]   ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_aligned;

  // Handshake and response bookkeeping
  assign is_load         = |pl_q.ld_op;
  assign pending         = mem_valid_q & is_load & pl_q.req_sent & ~buf_valid_q;
  // A response belongs to the current load only when no squashed load is
  // still waiting for its own response.
  assign resp_own        = data_sram_data_ok & (cnt_q == CNT_ZERO);
  assign mem_ready_go    = ~pending | resp_own;
  assign mem_allowin     = ~mem_valid_q | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid_q & mem_ready_go & ~flush;
  assign to_wb_fire      = mem_to_wb_valid & wb_allowin;
  assign buf_capture     = pending & resp_own & ~wb_allowin;
  // A flushed load still owes a response unless it arrives this very cycle.
  assign cnt_inc         = flush & pending & ~resp_own;
  assign cnt_dec         = data_sram_data_ok & (cnt_q != CNT_ZERO);

  // Payload capture; not reset, qualified everywhere by mem_valid
  always_ff @(posedge clk) begin
    if (ex_to_mem_valid && mem_allowin) begin
      pl_q.rf_we    <= ex_rf_we;
      pl_q.rf_waddr <= ex_rf_waddr;
      pl_q.pc       <= ex_pc;
      pl_q.result   <= ex_result;
      pl_q.ld_op    <= ex_ld_op;
      pl_q.req_sent <= ex_req_sent;
    end
  end

  // Response buffer data
  always_ff @(posedge clk) begin
    if (buf_capture) begin
      buf_data_q <= data_sram_rdata;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
      cnt_q       <= CNT_ZERO;
    end else begin
      mem_valid_q <= mem_valid_d;
      buf_valid_q <= buf_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state for valid, buffer flag and cancel counter
  always_comb begin
    mem_valid_d = mem_valid_q;
    buf_valid_d = buf_valid_q;
    cnt_d       = cnt_q;

    if (flush) begin
      mem_valid_d = 1'b0;
      buf_valid_d = 1'b0;
    end else begin
      if (mem_allowin) begin
        mem_valid_d = ex_to_mem_valid;
      end
      if (buf_capture) begin
        buf_valid_d = 1'b1;
      end else if (to_wb_fire) begin
        buf_valid_d = 1'b0;
      end
    end

    unique case ({cnt_inc, cnt_dec})
      2'b10: begin
        // Saturate: further squashed responses are no longer tracked
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Load data alignment and extension
  assign ld_word = buf_valid_q ? buf_data_q : data_sram_rdata;
  assign ld_byte = ld_word[{pl_q.result[1:0], 3'b000} +: 8];
  assign ld_half = ld_word[{pl_q.result[1], 4'b0000} +: 16];

  always_comb begin
    ld_aligned = ld_word;
    if (pl_q.ld_op[LD_B_BIT]) begin
      ld_aligned = {{24{ld_byte[7]}}, ld_byte};
    end else if (pl_q.ld_op[LD_BU_BIT]) begin
      ld_aligned = {24'h000000, ld_byte};
    end else if (pl_q.ld_op[LD_H_BIT]) begin
      ld_aligned = {{16{ld_half[15]}}, ld_half};
    end else if (pl_q.ld_op[LD_HU_BIT]) begin
      ld_aligned = {16'h0000, ld_half};
    end else if (pl_q.ld_op[LD_W_BIT]) begin
      ld_aligned = ld_word;
    end
  end

`ifdef MEM_RESP_FWD_EN
  assign fwd_ready = mem_ready_go;
`else
  assign fwd_ready = ~is_load;
`endif

  // Output payload; a load whose request was never issued writes nothing
  assign mem_rf_we    = pl_q.rf_we & ~(is_load & ~pl_q.req_sent);
  assign mem_rf_waddr = pl_q.rf_waddr;
  assign mem_pc       = pl_q.pc;
  assign mem_rf_wdata = is_load ? ld_aligned : pl_q.result;
  assign mem_rf_zip   = {mem_rf_we & mem_valid_q, fwd_ready, mem_rf_waddr, mem_rf_wdata};

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage with a transaction-level reference model.
module tb_mem_resp_stage;

  localparam logic [4:0] LD_NONE = 5'b00000;
  localparam logic [4:0] LD_B    = 5'b10000;
  localparam logic [4:0] LD_BU   = 5'b01000;
  localparam logic [4:0] LD_H    = 5'b00100;
  localparam logic [4:0] LD_HU   = 5'b00010;
  localparam logic [4:0] LD_W    = 5'b00001;
  localparam int         DROP_MAX = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_to_mem_valid, ex_rf_we, ex_req_sent;
  logic [4:0]  ex_rf_waddr, ex_ld_op;
  logic [31:0] ex_pc, ex_result;
  logic        data_sram_data_ok, flush, wb_allowin;
  logic [31:0] data_sram_rdata;
  logic        mem_allowin, mem_to_wb_valid, mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_rf_wdata, mem_pc;
  logic [38:0] mem_rf_zip;

  int checks = 0;
  int errors = 0;

  mem_resp_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .mem_allowin       (mem_allowin),
    .ex_rf_we          (ex_rf_we),
    .ex_rf_waddr       (ex_rf_waddr),
    .ex_pc             (ex_pc),
    .ex_result         (ex_result),
    .ex_ld_op          (ex_ld_op),
    .ex_req_sent       (ex_req_sent),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_rf_we         (mem_rf_we),
    .mem_rf_waddr      (mem_rf_waddr),
    .mem_rf_wdata      (mem_rf_wdata),
    .mem_pc            (mem_pc),
    .mem_rf_zip        (mem_rf_zip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: pick the addressed byte/half out of the word and extend it
  function automatic logic [31:0] align(input logic [4:0] op, input logic [1:0] a,
                                        input logic [31:0] w);
    logic [7:0]  b [4];
    logic [7:0]  sb;
    logic [15:0] h;
    b[0] = w[7:0];   b[1] = w[15:8];
    b[2] = w[23:16]; b[3] = w[31:24];
    sb = b[a];
    h  = a[1] ? {b[3], b[2]} : {b[1], b[0]};
    case (op)
      LD_B:    return {{24{sb[7]}}, sb};
      LD_BU:   return {24'h0, sb};
      LD_H:    return {{16{h[15]}}, h};
      LD_HU:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- reference model state ----------------
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  op;
    logic        sent;
  } ins_t;

  bit          m_valid = 1'b0;  // an instruction sits in MEM
  bit          m_got   = 1'b0;  // its response was already received and held
  logic [31:0] m_data  = '0;
  int          m_drop  = 0;     // responses still owed to squashed loads
  ins_t        m_ins;

  // Model update on each clock edge from the inputs of the finished cycle
  initial begin : model
    bit w, ours, done, allow;
    int nd;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_valid = 1'b0;
        m_got   = 1'b0;
        m_drop  = 0;
      end else begin
        w     = m_valid && (m_ins.op != 0) && m_ins.sent && !m_got;
        ours  = data_sram_data_ok && (m_drop == 0);
        done  = !w || ours;
        allow = !m_valid || (done && wb_allowin);
        nd = m_drop;
        if (data_sram_data_ok && m_drop > 0) nd = nd - 1;
        if (flush && w && !ours) nd = nd + 1;
        if (nd > DROP_MAX) nd = DROP_MAX;
        if (flush) begin
          m_valid = 1'b0;
          m_got   = 1'b0;
        end else begin
          if (w && ours && !wb_allowin) begin
            m_got  = 1'b1;
            m_data = data_sram_rdata;
          end else if (m_valid && done && wb_allowin) begin
            m_got = 1'b0;
          end
          if (allow) m_valid = ex_to_mem_valid;
        end
        if (ex_to_mem_valid && allow) begin
          m_ins.we     = ex_rf_we;
          m_ins.waddr  = ex_rf_waddr;
          m_ins.pc     = ex_pc;
          m_ins.result = ex_result;
          m_ins.op     = ex_ld_op;
          m_ins.sent   = ex_req_sent;
        end
        m_drop = nd;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  initial begin : compare
    bit w, done, e_allow, e_tow, e_we, e_fwd;
    logic [31:0] e_wdata;
    forever begin
      @(negedge clk);
      if (resetn) begin
        w       = m_valid && (m_ins.op != 0) && m_ins.sent && !m_got;
        done    = !w || (data_sram_data_ok && m_drop == 0);
        e_allow = !m_valid || (done && wb_allowin);
        e_tow   = m_valid && done && !flush;
        e_we    = m_ins.we && !((m_ins.op != 0) && !m_ins.sent);
`ifdef MEM_RESP_FWD_EN
        e_fwd = done;
`else
        e_fwd = (m_ins.op == 0);
`endif
        chk("cmp_allowin", 64'(mem_allowin), 64'(e_allow));
        chk("cmp_to_wb_valid", 64'(mem_to_wb_valid), 64'(e_tow));
        if (m_valid) begin
          chk("cmp_zip_we", 64'(mem_rf_zip[38]), 64'(e_we));
          chk("cmp_zip_fwd", 64'(mem_rf_zip[37]), 64'(e_fwd));
        end else begin
          chk("cmp_zip_we_idle", 64'(mem_rf_zip[38]), 64'(0));
        end
        if (e_tow) begin
          e_wdata = (m_ins.op != 0)
                    ? align(m_ins.op, m_ins.result[1:0], m_got ? m_data : data_sram_rdata)
                    : m_ins.result;
          chk("cmp_rf_we", 64'(mem_rf_we), 64'(e_we));
          chk("cmp_waddr", 64'(mem_rf_waddr), 64'(m_ins.waddr));
          chk("cmp_pc", 64'(mem_pc), 64'(m_ins.pc));
          chk("cmp_wdata", 64'(mem_rf_wdata), 64'(e_wdata));
          chk("cmp_zip_payload", 64'(mem_rf_zip[36:0]), 64'({m_ins.waddr, e_wdata}));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ex_to_mem_valid   = 1'b0;
    ex_rf_we          = 1'b0;
    ex_rf_waddr       = 5'd0;
    ex_pc             = 32'h0;
    ex_result         = 32'h0;
    ex_ld_op          = LD_NONE;
    ex_req_sent       = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    flush             = 1'b0;
    wb_allowin        = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic ex_put(input logic [4:0] op, input logic [31:0] res,
                        input logic sent, input logic [4:0] wa);
    ex_to_mem_valid = 1'b1;
    ex_rf_we        = 1'b1;
    ex_rf_waddr     = wa;
    ex_pc           = 32'h1C00_0000 + res;
    ex_result       = res;
    ex_ld_op        = op;
    ex_req_sent     = sent;
  endtask

  task automatic resp(input logic [31:0] d);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = d;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // ---------------- directed vectors ----------------
  initial begin : stim
    idle();
    #2;
    chk("rst_allowin", 64'(mem_allowin), 64'(1));
    chk("rst_to_wb_valid", 64'(mem_to_wb_valid), 64'(0));
    chk("rst_zip_we", 64'(mem_rf_zip[38]), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();

    // Non-load add result goes straight through
    ex_put(LD_NONE, 32'h0000_1234, 1'b0, 5'd3); tick();
    @(negedge clk);
    chk("add_to_wb_valid", 64'(mem_to_wb_valid), 64'(1));
    chk("add_wdata", 64'(mem_rf_wdata), 64'h0000_1234);
    chk("add_zip_fwd", 64'(mem_rf_zip[37]), 64'(1));
    chk("add_zip_we", 64'(mem_rf_zip[38]), 64'(1));
    tick();

    // Non-load stream with a WB stall
    ex_put(LD_NONE, 32'h11, 1'b0, 5'd1); tick();
    ex_put(LD_NONE, 32'h22, 1'b0, 5'd2); wb_allowin = 1'b0;
    @(negedge clk);
    chk("stall_allowin", 64'(mem_allowin), 64'(0));
    chk("stall_wdata", 64'(mem_rf_wdata), 64'h11);
    tick();
    ex_put(LD_NONE, 32'h22, 1'b0, 5'd2);
    @(negedge clk); chk("resume_allowin", 64'(mem_allowin), 64'(1)); tick();
    ex_put(LD_NONE, 32'h33, 1'b0, 5'd4);
    @(negedge clk); chk("stream_wdata_22", 64'(mem_rf_wdata), 64'h22); tick();
    @(negedge clk); chk("stream_wdata_33", 64'(mem_rf_wdata), 64'h33); tick();

    // Load whose request was never issued completes without writing
    ex_put(LD_B, 32'h0000_2001, 1'b0, 5'd7); tick();
    @(negedge clk);
    chk("nosent_to_wb_valid", 64'(mem_to_wb_valid), 64'(1));
    chk("nosent_rf_we", 64'(mem_rf_we), 64'(0));
    chk("nosent_zip_we", 64'(mem_rf_zip[38]), 64'(0));
    tick();

    // ld_b at byte 3, response in the first MEM cycle
    ex_put(LD_B, 32'h0000_1003, 1'b1, 5'd5); tick();
    resp(32'h8011_2233);
    @(negedge clk);
    chk("ldb_to_wb_valid", 64'(mem_to_wb_valid), 64'(1));
    chk("ldb_wdata", 64'(mem_rf_wdata), 64'hFFFF_FF80);
    tick();

    // ld_hu buffered while WB stalls, later SRAM data ignored
    ex_put(LD_HU, 32'h0000_2002, 1'b1, 5'd6); tick();
    resp(32'hBEEF_1234); wb_allowin = 1'b0;
    @(negedge clk); chk("ldhu_allowin_stall", 64'(mem_allowin), 64'(0)); tick();
    wb_allowin = 1'b0; data_sram_rdata = 32'hDEAD_DEAD;
    @(negedge clk); chk("ldhu_buf_wdata_a", 64'(mem_rf_wdata), 64'h0000_BEEF); tick();
    data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("ldhu_buf_to_wb", 64'(mem_to_wb_valid), 64'(1));
    chk("ldhu_buf_wdata_b", 64'(mem_rf_wdata), 64'h0000_BEEF);
    tick();

    // Flushed pending load: its late response is dropped
    ex_put(LD_W, 32'h0000_3000, 1'b1, 5'd8); tick();
    flush = 1'b1;
    @(negedge clk); chk("flush_to_wb_valid", 64'(mem_to_wb_valid), 64'(0)); tick();
    ex_put(LD_W, 32'h0000_3004, 1'b1, 5'd9); tick();
    resp(32'hAAAA_0000);
    @(negedge clk); chk("stale_to_wb_valid", 64'(mem_to_wb_valid), 64'(0)); tick();
    resp(32'h1234_5678);
    @(negedge clk);
    chk("second_to_wb_valid", 64'(mem_to_wb_valid), 64'(1));
    chk("second_wdata", 64'(mem_rf_wdata), 64'h1234_5678);
    tick();

    // Flush together with the load's own response: nothing left owed,
    // and the EX load offered in that cycle is dropped
    ex_put(LD_W, 32'h0000_3100, 1'b1, 5'd10); tick();
    flush = 1'b1; resp(32'h0BAD_0BAD);
    ex_put(LD_W, 32'h0000_3200, 1'b1, 5'd11);
    tick();
    @(negedge clk);
    chk("flushok_empty_allowin", 64'(mem_allowin), 64'(1));
    chk("flushok_empty_tow", 64'(mem_to_wb_valid), 64'(0));
    tick();
    ex_put(LD_BU, 32'h0000_3300, 1'b1, 5'd12); tick();
    resp(32'h0000_00FF);
    @(negedge clk);
    chk("flushok_next_tow", 64'(mem_to_wb_valid), 64'(1));
    chk("flushok_next_wdata", 64'(mem_rf_wdata), 64'h0000_00FF);
    tick();

    // Forward-ready marking of an ld_w around its response
    ex_put(LD_W, 32'h0000_6000, 1'b1, 5'd13); tick();
    @(negedge clk); chk("ldw_wait_fwd", 64'(mem_rf_zip[37]), 64'(0)); tick();
    resp(32'h0102_0304);
    @(negedge clk);
`ifdef MEM_RESP_FWD_EN
    chk("ldw_dataok_fwd", 64'(mem_rf_zip[37]), 64'(1));
`else
    chk("ldw_dataok_fwd", 64'(mem_rf_zip[37]), 64'(0));
`endif
    chk("ldw_dataok_h", 64'(mem_rf_wdata), 64'h0102_0304);
    tick();

    // Four squashed loads: counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      ex_put(LD_W, 32'h0000_4000 + 32'(i * 4), 1'b1, 5'd14); tick();
      flush = 1'b1; tick();
    end
    ex_put(LD_W, 32'h0000_4100, 1'b1, 5'd15); tick();
    for (int i = 0; i < 3; i++) begin
      resp(32'hBAD0_0000 + 32'(i));
      @(negedge clk); chk("sat_drop_tow", 64'(mem_to_wb_valid), 64'(0)); tick();
    end
    resp(32'h600D_600D);
    @(negedge clk);
    chk("sat_take_tow", 64'(mem_to_wb_valid), 64'(1));
    chk("sat_take_wdata", 64'(mem_rf_wdata), 64'h600D_600D);
    tick();

    // Asynchronous reset while a load is pending with one response owed
    ex_put(LD_W, 32'h0000_5000, 1'b1, 5'd16); tick();
    flush = 1'b1; tick();
    ex_put(LD_W, 32'h0000_5004, 1'b1, 5'd17); tick();
    #1;
    chk("prerst_allowin", 64'(mem_allowin), 64'(0));
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_allowin", 64'(mem_allowin), 64'(1));
    chk("midrst_to_wb_valid", 64'(mem_to_wb_valid), 64'(0));
    chk("midrst_zip_we", 64'(mem_rf_zip[38]), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();
    ex_put(LD_W, 32'h0000_5008, 1'b1, 5'd18); tick();
    resp(32'hC0FF_EE00);
    @(negedge clk);
    chk("postrst_tow", 64'(mem_to_wb_valid), 64'(1));
    chk("postrst_wdata", 64'(mem_rf_wdata), 64'hC0FF_EE00);
    tick();

    // Signed half at upper half-word
    ex_put(LD_H, 32'h0000_7002, 1'b1, 5'd19); tick();
    resp(32'h8001_7FFF);
    @(negedge clk); chk("ldh_wdata", 64'(mem_rf_wdata), 64'hFFFF_8001); tick();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
